// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR demo run/display sequencer.
// Digit groups are indexed from the least significant end: group 0 holds digits 2..0.
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT,
        ST_SHOW_BLANK,
        ST_SHOW_HI,
        ST_SHOW_MID,
        ST_SHOW_LO
    } state_e;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 9;
    localparam int SEG_DIGITS = 3;
    localparam int SNAP_W     = DIGIT_W * NUM_DIGITS;
    localparam int SEG_W      = DIGIT_W * SEG_DIGITS;

    localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;
    localparam logic [SEG_W-1:0]   BLANK_FRAME = {SEG_DIGITS{BLANK_DIGIT}};
    localparam logic [SNAP_W-1:0]  BLANK_SNAP  = {NUM_DIGITS{BLANK_DIGIT}};

    function automatic logic [SEG_W-1:0] digit_group(input logic [SNAP_W-1:0] snap,
                                                     input logic [1:0]        grp);
        logic [SEG_W-1:0] g;
        case (grp)
            2'd2:    g = snap[2*SEG_W +: SEG_W];
            2'd1:    g = snap[1*SEG_W +: SEG_W];
            default: g = snap[0 +: SEG_W];
        endcase
        return g;
    endfunction

endpackage

// File: rtl/fir_run_controller_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, and a one-cycle
// press pulse on each accepted high-to-low transition of the active-low button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The accepted level doubles as the release lockout: a second press pulse can only
    // follow once a high level has itself been accepted.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/fir_run_controller.sv
// Run/display sequencer: toggles run on a debounced press, strobes one sample per
// four-tick display frame, handshakes with the BCD converter and schedules its digits.
module fir_run_controller
    import fir_ctrl_pkg::*;
#(
    parameter int TICK_DIV        = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int BCD_TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_n,
    output logic              sample_en,
    output logic              src_rst,
    output logic              bcd_start,
    input  logic              bcd_done,
    input  logic [SNAP_W-1:0] bcd_digits,
    output logic [SEG_W-1:0]  seg_bcd,
    output logic              running,
    output logic              err
);
    localparam int TICK_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int WAIT_W = $clog2(BCD_TIMEOUT + 1);

    logic press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n),
        .press (press)
    );

    state_e              state_q, state_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                err_q, err_d;
    logic                tick;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic                running_q, src_rst_q, sample_en_q, bcd_start_q;

    assign tick = (tick_q == TICK_W'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        tick_d  = '0;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_SAMPLE;
                    err_d   = 1'b0;
                end
            end
            ST_SAMPLE: begin
                state_d = ST_CONVERT;
                wait_d  = '0;
            end
            ST_CONVERT: begin
                // wait_q==k means bcd_start has been visible for k cycles.
                wait_d = wait_q + WAIT_W'(1);
                if (bcd_done) begin
                    snap_d  = bcd_digits;
                    state_d = ST_SHOW_BLANK;
                end else if (wait_q == WAIT_W'(BCD_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_SHOW_BLANK;
                end
            end
            default: begin
                tick_d = tick ? '0 : tick_q + TICK_W'(1);
                if (tick) begin
                    case (state_q)
                        ST_SHOW_BLANK: state_d = ST_SHOW_HI;
                        ST_SHOW_HI:    state_d = ST_SHOW_MID;
                        ST_SHOW_MID:   state_d = ST_SHOW_LO;
                        default:       state_d = ST_SAMPLE;
                    endcase
                end
            end
        endcase
        // A stop press overrides any completion or tick in the same cycle.
        if (press && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            snap_d  = snap_q;
            err_d   = err_q;
            tick_d  = '0;
        end
    end

    always_comb begin
        seg_d = BLANK_FRAME;
        case (state_d)
            ST_SHOW_HI:  seg_d = digit_group(snap_d, 2'd2);
            ST_SHOW_MID: seg_d = digit_group(snap_d, 2'd1);
            ST_SHOW_LO:  seg_d = digit_group(snap_d, 2'd0);
            default:     seg_d = BLANK_FRAME;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            snap_q      <= BLANK_SNAP;
            tick_q      <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
            seg_q       <= BLANK_FRAME;
            running_q   <= 1'b0;
            src_rst_q   <= 1'b1;
            sample_en_q <= 1'b0;
            bcd_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            tick_q      <= tick_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            seg_q       <= seg_d;
            running_q   <= (state_d != ST_IDLE);
            src_rst_q   <= (state_d == ST_IDLE);
            sample_en_q <= (state_q == ST_SAMPLE) && !press;
            bcd_start_q <= (state_q == ST_CONVERT) && (wait_q == '0) && !press;
        end
    end

    assign sample_en = sample_en_q;
    assign src_rst   = src_rst_q;
    assign bcd_start = bcd_start_q;
    assign seg_bcd   = seg_q;
    assign running   = running_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fir_run_controller.sv
// Directed bench for fir_run_controller with TICK_DIV=4, DEBOUNCE_CYCLES=3, BCD_TIMEOUT=8.
// Cycle k is the interval right after rising edge k; inputs and samples sit 1 ns into it.
module tb_fir_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_n;
    logic        sample_en;
    logic        src_rst;
    logic        bcd_start;
    logic        bcd_done;
    logic [35:0] bcd_digits;
    logic [11:0] seg_bcd;
    logic        running;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    fir_run_controller #(
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (3),
        .BCD_TIMEOUT     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .sample_en  (sample_en),
        .src_rst    (src_rst),
        .bcd_start  (bcd_start),
        .bcd_done   (bcd_done),
        .bcd_digits (bcd_digits),
        .seg_bcd    (seg_bcd),
        .running    (running),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) step();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_running"},   36'(running),   36'h0);
        check_val({tag, "_src_rst"},   36'(src_rst),   36'h1);
        check_val({tag, "_sample_en"}, 36'(sample_en), 36'h0);
        check_val({tag, "_bcd_start"}, 36'(bcd_start), 36'h0);
        check_val({tag, "_seg"},       36'(seg_bcd),   36'hFFF);
        check_val({tag, "_err"},       36'(err),       36'h0);
    endtask

    logic [11:0] frame_exp [4] = '{12'hFFF, 12'h000, 12'h123, 12'h456};

    initial begin
        int a, s, b;
        bit saw_sample;

        rst        = 1'b1;
        btn_n      = 1'b1;
        bcd_done   = 1'b0;
        bcd_digits = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        cyc = 0;

        // Idle with the button released.
        saw_sample = 1'b0;
        repeat (50) begin
            step();
            if (sample_en) saw_sample = 1'b1;
        end
        check_val("idle_seg", 36'(seg_bcd), 36'hFFF);
        check_val("idle_src_rst", 36'(src_rst), 36'h1);
        check_val("idle_no_sample", 36'(saw_sample), 36'h0);
        $display("idle: seg=%h src_rst=%0b", seg_bcd, src_rst);

        // Short glitches must not register as a press.
        repeat (3) begin
            btn_n = 1'b0;
            repeat (2) step();
            btn_n = 1'b1;
            repeat (4) step();
        end
        check_val("glitch_running", 36'(running), 36'h0);
        $display("glitch: running=%0b", running);

        // Start press: press pulse in cycle a+5.
        a = cyc;
        btn_n = 1'b0;
        goto(a + 5);
        btn_n = 1'b1;
        check_val("start_latency_running", 36'(running), 36'h0);
        goto(a + 6);
        check_val("start_running", 36'(running), 36'h1);
        check_val("start_src_rst", 36'(src_rst), 36'h0);
        goto(a + 7);
        check_val("start_sample_en", 36'(sample_en), 36'h1);
        goto(a + 8);
        check_val("start_bcd_start", 36'(bcd_start), 36'h1);
        check_val("start_sample_drop", 36'(sample_en), 36'h0);
        s = a + 8;

        goto(s + 3);
        bcd_done   = 1'b1;
        bcd_digits = 36'h0_0012_3456;
        for (int i = 0; i < 16; i++) begin
            goto(s + 4 + i);
            if (i == 0) bcd_done = 1'b0;
            check_val($sformatf("frame%0d", i), 36'(seg_bcd), 36'(frame_exp[i/4]));
        end
        $display("run1: frame 000/123/456 shown");

        // Stop press timed to land on the same cycle as the second bcd_done (s+24).
        btn_n = 1'b0;
        goto(s + 21);
        check_val("run1_next_sample_en", 36'(sample_en), 36'h1);
        goto(s + 22);
        check_val("run1_next_bcd_start", 36'(bcd_start), 36'h1);
        goto(s + 24);
        btn_n      = 1'b1;
        bcd_done   = 1'b1;
        bcd_digits = 36'h9_8765_4321;
        goto(s + 25);
        bcd_done = 1'b0;
        check_val("stop_running", 36'(running), 36'h0);
        check_val("stop_src_rst", 36'(src_rst), 36'h1);
        check_val("stop_seg", 36'(seg_bcd), 36'hFFF);
        $display("stop with done: running=%0b seg=%h", running, seg_bcd);

        // Restart with no bcd_done: timeout, then display of the retained snapshot.
        goto(s + 30);
        a = cyc;
        btn_n = 1'b0;
        goto(a + 5);
        btn_n = 1'b1;
        goto(a + 6);
        check_val("to_running", 36'(running), 36'h1);
        b = a + 8;
        goto(b);
        check_val("to_bcd_start", 36'(bcd_start), 36'h1);
        goto(b + 7);
        check_val("to_err_before", 36'(err), 36'h0);
        goto(b + 8);
        check_val("to_err_set", 36'(err), 36'h1);
        check_val("to_blank", 36'(seg_bcd), 36'hFFF);
        goto(b + 12);
        check_val("to_snap_hi", 36'(seg_bcd), 36'h000);
        goto(b + 16);
        check_val("to_snap_mid", 36'(seg_bcd), 36'h123);
        goto(b + 20);
        check_val("to_snap_lo", 36'(seg_bcd), 36'h456);
        $display("timeout: err=%0b", err);

        // Stop keeps err; the following start clears it.
        a = cyc;
        btn_n = 1'b0;
        goto(a + 5);
        btn_n = 1'b1;
        goto(a + 6);
        check_val("stop2_running", 36'(running), 36'h0);
        check_val("stop2_err_sticky", 36'(err), 36'h1);
        goto(a + 11);
        a = cyc;
        btn_n = 1'b0;
        goto(a + 5);
        btn_n = 1'b1;
        goto(a + 6);
        check_val("restart_err_clear", 36'(err), 36'h0);
        check_val("restart_running", 36'(running), 36'h1);
        $display("restart: err=%0b running=%0b", err, running);

        // Asynchronous reset while SHOW_MID is on display.
        b = a + 8;
        goto(b + 17);
        check_val("mid_before_rst", 36'(seg_bcd), 36'h123);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step();
        a = cyc;
        btn_n = 1'b0;
        goto(a + 5);
        btn_n = 1'b1;
        goto(a + 6);
        check_val("post_rst_running", 36'(running), 36'h1);
        goto(a + 7);
        check_val("post_rst_sample_en", 36'(sample_en), 36'h1);
        $display("post reset restart: sample_en=%0b", sample_en);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_run_controller.md
# fir_run_controller

Run/display sequencer for the FIR moving-average demo. Converts the raw start/stop pushbutton into a debounced run toggle and derives a sample strobe from the 50 MHz clock, replacing the separate slow clock. Sequences each sample through the LFSR source, the moving-average filter and the binary-to-BCD converter with a start/done handshake. Schedules the 9-digit result onto the three 7-segment decoders as a blank frame followed by three digit groups.

## Interface
- TICK_DIV, 25_000_000: clk cycles per display-phase tick (0.5 s at 50 MHz); legal values are ≥ 2.
- DEBOUNCE_CYCLES, 500_000: cycles the synchronized button must be stable before its level is accepted.
- BCD_TIMEOUT, 64: maximum cycles to wait for bcd_done.
- clk  in  1  system clock (CLOCK_50 domain); the only clock.
- rst  in  1  reset; asynchronous, active-high.
- btn_n  in  1  raw pushbutton, active-low, asynchronous to clk.
- sample_en  out  1  one-cycle strobe; advances the LFSR and the moving average by one sample.
- src_rst  out  1  holds the LFSR and filter in reset while stopped.
- bcd_start  out  1  one-cycle request to the BCD converter.
- bcd_done  in  1  one-cycle converter completion; bcd_digits is valid in the same cycle.
- bcd_digits  in  36  nine BCD digits; digit 0 is in [3:0] and digit 8 is in [35:32].
- seg_bcd  out  12  three digits for HEX2/HEX1/HEX0 in [11:8]/[7:4]/[3:0]; 4'hF means blank.
- running  out  1  run state.
- err  out  1  sticky conversion-timeout flag.

## Operation
- Button path: 2-flop synchronizer, then the debouncer. A press event fires once per accepted high→low transition. A new event requires an accepted release first.
- A press event toggles `running`.
- States: IDLE, SAMPLE, CONVERT, SHOW_BLANK, SHOW_HI, SHOW_MID, SHOW_LO.
- IDLE
  - Outputs: src_rst=1, seg_bcd=12'hFFF, tick counter held at 0.
  - Press → SAMPLE on the next cycle and clear err.
- SAMPLE
  - Lasts 1 cycle; sample_en=1.
  - Next state is CONVERT.
- CONVERT
  - bcd_start=1 in the first cycle only.
  - bcd_done → latch bcd_digits into the snapshot and go to SHOW_BLANK.
  - BCD_TIMEOUT cycles with no done → set err, keep the old snapshot, go to SHOW_BLANK.
- SHOW_BLANK: seg_bcd=12'hFFF.
- SHOW_HI: seg_bcd = digits 8,7,6.
- SHOW_MID: seg_bcd = digits 5,4,3.
- SHOW_LO: seg_bcd = digits 2,1,0.
- Show-state sequencing: each show state advances on a tick. SHOW_LO + tick → SAMPLE, giving one sample per 4-tick frame.
- Tick counter
  - Counts 0..TICK_DIV-1 in the show states; a tick occurs at TICK_DIV-1 and the counter wraps to 0.
  - The counter is cleared on entry to SHOW_BLANK.
- Stop
  - A press in any non-IDLE state → IDLE on the next cycle.
  - The conversion in flight is abandoned; a late bcd_done is ignored.
- Simultaneous events
  - Press together with bcd_done: the stop wins and the snapshot is not updated.
  - Press together with a tick: the stop wins.
- The snapshot resets to all-F. It is retained across stop/start.

## Timing
- Reset values: state IDLE, running 0, src_rst 1, sample_en 0, bcd_start 0, seg_bcd 12'hFFF, err 0, snapshot all-F, debouncer level "released".
- All outputs are registered.
- Start press event at cycle n:
  - running=1 and src_rst=0 at n+1.
  - sample_en at n+2.
  - bcd_start at n+3.
- bcd_done at cycle m → SHOW_BLANK seg_bcd at m+1.
- Each SHOW_HI/MID/LO value is visible for exactly TICK_DIV cycles. SHOW_BLANK is likewise TICK_DIV cycles.
- Press recognized DEBOUNCE_CYCLES+2 cycles after the raw edge settles.
- Timeout: err=1 in the cycle after the BCD_TIMEOUT-th waiting cycle.
- Mid-operation rst forces the reset values immediately, asynchronously.

## Structure
- Package fir_ctrl_pkg:
  - state enum;
  - BLANK_DIGIT = 4'hF;
  - DIGIT_W = 4;
  - NUM_DIGITS = 9;
  - SEG_DIGITS = 3.
- Sub-module btn_debounce (clk, rst, btn_n → press pulse). It contains the synchronizer, stable counter and release lockout.
- The top level instantiates fir_run_controller in place of the toggle/slow-clock logic. CLOCK_50 → clk.

## Test plan
All scenarios use TICK_DIV=4, DEBOUNCE_CYCLES=3, BCD_TIMEOUT=8.
- Reset, then btn_n held high for 50 cycles → seg_bcd=12'hFFF, src_rst=1, no sample_en.
- Press 5 cycles low then release; bcd_done 3 cycles after bcd_start with bcd_digits=36'h0_0012_3456 → display sequence FFF (4 cycles), 000, 123, 456 (4 cycles each). The next sample_en follows immediately.
- Glitches of 2-cycle low pulses on btn_n → no press event; running stays 0.
- bcd_done never arrives → err=1 after 8 waiting cycles. The display shows the previous snapshot. The next start press clears err.
- Stop press landing on the same cycle as bcd_done → IDLE next cycle, snapshot unchanged, seg_bcd=12'hFFF, src_rst=1.
- rst asserted during SHOW_MID → all reset values in the same cycle. After release, a press restarts from SAMPLE.
